param_mem: RTL and testbench
============================

PARAM_MEM -- requirements
Module: param_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width in bits (1..64).
REQ-002 SHALL have parameter ADDR_W, default 8, address width; depth is 2**ADDR_W words.
REQ-003 SHALL have parameter RD_LAT, default 1, read latency in clock cycles (1..4).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port cs_n  input  1  chip select, active-low.
REQ-007 SHALL have port rd_n  input  1  read strobe, active-low.
REQ-008 SHALL have port wr_n  input  1  write strobe, active-low.
REQ-009 SHALL have port addr  input  ADDR_W  word address.
REQ-010 SHALL have port data_in  input  DATA_W  write data.
REQ-011 SHALL have port data_out  output  DATA_W  registered read data.
REQ-012 SHALL have port data_valid  output  1  one-cycle pulse marking new read data on data_out.
REQ-013 SHALL have port busy  output  1  high while a read is in flight; commands ignored.
REQ-014 SHALL have port cmd_err  output  1  one-cycle pulse on an illegal command.

Function
REQ-015 Command sampling: every rising edge with busy=0 and cs_n=0; cs_n=1 means no command.
REQ-016 Write: cs_n=0, wr_n=0, rd_n=1 -> mem[addr] <= data_in at that edge; busy stays 0; back-to-back writes every cycle accepted.
REQ-017 Read: cs_n=0, rd_n=0, wr_n=1 -> addr latched; FSM IDLE -> WAIT; busy=1 from next cycle.
REQ-018 FSM states IDLE, WAIT, DONE; WAIT counts RD_LAT-1 cycles (zero when RD_LAT=1), then DONE for one cycle, then IDLE.
REQ-019 Read latency: data_out updated and data_valid=1 exactly RD_LAT cycles after the accepting edge; busy falls in that same cycle.
REQ-020 Next command accepted on the edge where data_valid=1 (read-to-read throughput RD_LAT cycles).
REQ-021 data_out holds the last read value until the next read completes; never driven to Z.
REQ-022 Illegal command cs_n=0, rd_n=0, wr_n=0 with busy=0 -> no memory change, no read started, cmd_err=1 for one cycle.
REQ-023 Commands while busy=1 are ignored, no cmd_err; memory and in-flight read unaffected.
REQ-024 Read returns the latched address content as of the accepting edge; a write to the same address on that edge is impossible (busy rules).
REQ-025 Read of a never-written address returns undefined data; data_valid timing still per REQ-019.
REQ-026 Address wraps naturally at 2**ADDR_W; no out-of-range condition exists.

Reset
REQ-027 rst=1 at an edge -> FSM IDLE, busy=0, data_valid=0, cmd_err=0, data_out=0, latency counter 0.
REQ-028 Reset mid-read aborts the read; no data_valid pulse follows.
REQ-029 Memory array contents not cleared by reset; rst has priority over any command on the same edge.

Configuration
REQ-030 Macro PARAM_MEM_PARITY_EN defined -> one even-parity bit stored per word on write and output par_err (1 bit) added.
REQ-031 With PARAM_MEM_PARITY_EN, par_err asserts with data_valid when stored parity mismatches stored data; reset value 0; undefined for never-written words.
REQ-032 Without PARAM_MEM_PARITY_EN, no parity storage and no par_err port; all other behaviour identical.

Verification
REQ-033 Defaults: write 0xAB to 0x10, read 0x10 -> data_out=0xAB, data_valid 1 cycle after accept, busy high 1 cycle.
REQ-034 RD_LAT=3: write 0x5A to 0xFF, read 0xFF -> data_valid exactly 3 cycles later, busy high 3 cycles, data_out=0x5A.
REQ-035 Read 0x10 accepted, read 0x20 issued next cycle while busy -> only one data_valid (0x10 data); 0x20 ignored.
REQ-036 cs_n=0, rd_n=0, wr_n=0 at 0x10 holding 0xAB -> cmd_err pulse, later read 0x10 still returns 0xAB.
REQ-037 rst asserted one cycle into a RD_LAT=3 read -> no data_valid, data_out=0, busy=0 next cycle.
REQ-038 DATA_W=16, PARAM_MEM_PARITY_EN: write 0x1234 to 0x03, read back -> data_out=0x1234, par_err=0.

Source files
------------

// File: rtl/param_mem.sv
// Single-port parameterised word memory with strobe-style commands and a fixed read latency.
// Optional per-word even parity and a par_err output when PARAM_MEM_PARITY_EN is defined.
module param_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              busy,
    output logic              cmd_err
`ifdef PARAM_MEM_PARITY_EN
    ,
    output logic              par_err
`endif
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                data_valid_q, data_valid_d;
    logic                busy_q, busy_d;
    logic                cmd_err_q, cmd_err_d;
    logic                mem_we;
    logic [DATA_W-1:0]   mem_q [DEPTH];

`ifdef PARAM_MEM_PARITY_EN
    logic                par_q [DEPTH];
    logic                par_err_q, par_err_d;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rd_addr_d    = rd_addr_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        cmd_err_d    = 1'b0;
        mem_we       = 1'b0;
`ifdef PARAM_MEM_PARITY_EN
        par_err_d    = 1'b0;
`endif

        case (state_q)
            ST_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d      = ST_DONE;
                    cnt_d        = '0;
                    data_out_d   = mem_q[rd_addr_q];
                    data_valid_d = 1'b1;
`ifdef PARAM_MEM_PARITY_EN
                    par_err_d    = (^mem_q[rd_addr_q]) != par_q[rd_addr_q];
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // The DONE cycle is not busy, so a new command may be taken on the edge that ends it.
        if (state_q != ST_WAIT && !cs_n) begin
            if (!wr_n && rd_n) begin
                mem_we = 1'b1;
            end else if (!rd_n && wr_n) begin
                state_d   = ST_WAIT;
                cnt_d     = '0;
                rd_addr_d = addr;
            end else if (!rd_n && !wr_n) begin
                cmd_err_d = 1'b1;
            end
        end

        busy_d = (state_d == ST_WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            rd_addr_q    <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_addr_q    <= rd_addr_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            busy_q       <= busy_d;
            cmd_err_q    <= cmd_err_d;
        end
    end

    // Storage is never cleared; reset only suppresses a write presented on the same edge.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[addr] <= data_in;
        end
    end

`ifdef PARAM_MEM_PARITY_EN
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            par_q[addr] <= ^data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign par_err = par_err_q;
`endif

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign busy       = busy_q;
    assign cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_param_mem.sv
// Bench for param_mem: a default instance (RD_LAT=1, 8-bit) and a RD_LAT=3, 16-bit instance,
// both checked against an array-based memory model with the latency rule applied directly.
module tb_param_mem;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       cs_n = 2'b11;
    logic [1:0]       rd_n = 2'b11;
    logic [1:0]       wr_n = 2'b11;
    logic [1:0][7:0]  addr_v = '0;
    logic [1:0][15:0] din_v = '0;
    logic [7:0]       dout0;
    logic [15:0]      dout1;
    logic [1:0]       dv, busy, err;
`ifdef PARAM_MEM_PARITY_EN
    logic [1:0]       perr;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] ref_mem   [2][256];
    bit          ref_valid [2][256];

    always #5 clk = ~clk;

    param_mem u_dut0 (
        .clk(clk), .rst(rst), .cs_n(cs_n[0]), .rd_n(rd_n[0]), .wr_n(wr_n[0]),
        .addr(addr_v[0]), .data_in(din_v[0][7:0]), .data_out(dout0),
        .data_valid(dv[0]), .busy(busy[0]), .cmd_err(err[0])
`ifdef PARAM_MEM_PARITY_EN
        , .par_err(perr[0])
`endif
    );

    param_mem #(.DATA_W(16), .ADDR_W(8), .RD_LAT(3)) u_dut1 (
        .clk(clk), .rst(rst), .cs_n(cs_n[1]), .rd_n(rd_n[1]), .wr_n(wr_n[1]),
        .addr(addr_v[1]), .data_in(din_v[1]), .data_out(dout1),
        .data_valid(dv[1]), .busy(busy[1]), .cmd_err(err[1])
`ifdef PARAM_MEM_PARITY_EN
        , .par_err(perr[1])
`endif
    );

    function automatic logic [15:0] dout_of(input int idx);
        return (idx == 0) ? {8'h00, dout0} : dout1;
    endfunction

    function automatic int lat_of(input int idx);
        return (idx == 0) ? 1 : 3;
    endfunction

    function automatic logic [15:0] mask_of(input int idx);
        return (idx == 0) ? 16'h00FF : 16'hFFFF;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int idx, input logic c, input logic r, input logic w,
                           input logic [7:0] a, input logic [15:0] d);
        cs_n[idx]   = c;
        rd_n[idx]   = r;
        wr_n[idx]   = w;
        addr_v[idx] = a;
        din_v[idx]  = d;
    endtask

    task automatic set_idle(input int idx);
        set_cmd(idx, 1'b1, 1'b1, 1'b1, 8'h00, 16'h0000);
    endtask

    task automatic write_op(input int idx, input logic [7:0] a, input logic [15:0] d);
        set_cmd(idx, 1'b0, 1'b1, 1'b0, a, d & mask_of(idx));
        cycle();
        set_idle(idx);
        ref_mem[idx][a]   = d & mask_of(idx);
        ref_valid[idx][a] = 1'b1;
    endtask

    task automatic read_op(input int idx, input logic [7:0] a, output bit got, output int lat,
                           output int busy_cycles, output logic [15:0] d, output logic busy_at_dv);
        set_cmd(idx, 1'b0, 1'b0, 1'b1, a, 16'h0000);
        cycle();
        set_idle(idx);
        got = 1'b0;
        lat = 0;
        busy_cycles = 0;
        d = '0;
        busy_at_dv = 1'bx;
        for (int k = 1; k <= 12; k++) begin
            if (busy[idx]) busy_cycles++;
            cycle();
            if (dv[idx]) begin
                got = 1'b1;
                lat = k;
                d = dout_of(idx);
                busy_at_dv = busy[idx];
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle(0);
        set_idle(1);
        cycle();
        cycle();
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (dout_of(i) !== 16'h0000) begin
                miscompares++;
                $display("[TB] FAIL reset_data_out inst%0d got %h want 0000", i, dout_of(i));
            end
            vectors++;
            if ({dv[i], busy[i], err[i]} !== 3'b000) begin
                miscompares++;
                $display("[TB] FAIL reset_flags inst%0d got dv/busy/err=%b want 000", i, {dv[i], busy[i], err[i]});
            end
        end
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_basic();
        bit got; int lat, bc; logic [15:0] d; logic bdv;
        write_op(0, 8'h10, 16'h00AB);
        vectors++;
        if (busy[0] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL basic_write_busy got %b want 0", busy[0]);
        end
        read_op(0, 8'h10, got, lat, bc, d, bdv);
        vectors++;
        if (!got || lat != 1 || bc != 1 || bdv !== 1'b0 || d !== 16'h00AB) begin
            miscompares++;
            $display("[TB] FAIL basic_read got valid=%0d lat=%0d busy_cyc=%0d busy_at_dv=%b data=%h want 1/1/1/0/00ab",
                     got, lat, bc, bdv, d);
        end
        cycle();
        vectors++;
        if (dv[0] !== 1'b0 || dout0 !== 8'hAB) begin
            miscompares++;
            $display("[TB] FAIL basic_hold got dv=%b data=%h want dv=0 data=ab", dv[0], dout0);
        end
    endtask

    task automatic test_rdlat3();
        bit got; int lat, bc; logic [15:0] d; logic bdv;
        write_op(1, 8'hFF, 16'h005A);
        read_op(1, 8'hFF, got, lat, bc, d, bdv);
        vectors++;
        if (!got || lat != 3 || bc != 3 || bdv !== 1'b0 || d !== 16'h005A) begin
            miscompares++;
            $display("[TB] FAIL rdlat3_read got valid=%0d lat=%0d busy_cyc=%0d busy_at_dv=%b data=%h want 1/3/3/0/005a",
                     got, lat, bc, bdv, d);
        end
    endtask

    task automatic test_busy_ignore();
        bit got; int lat, bc, pulses; logic [15:0] d; logic bdv;
        write_op(0, 8'h20, 16'h0077);
        set_cmd(0, 1'b0, 1'b0, 1'b1, 8'h10, 16'h0000);
        cycle();
        set_cmd(0, 1'b0, 1'b0, 1'b1, 8'h20, 16'h0000);
        cycle();
        set_idle(0);
        vectors++;
        if (dv[0] !== 1'b1 || dout0 !== 8'hAB) begin
            miscompares++;
            $display("[TB] FAIL busy_first_read got dv=%b data=%h want 1/ab", dv[0], dout0);
        end
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            if (dv[0]) pulses++;
        end
        vectors++;
        if (pulses != 0 || dout0 !== 8'hAB) begin
            miscompares++;
            $display("[TB] FAIL busy_ignored_read got extra_pulses=%0d data=%h want 0/ab", pulses, dout0);
        end

        write_op(1, 8'h50, 16'h0011);
        set_cmd(1, 1'b0, 1'b0, 1'b1, 8'hFF, 16'h0000);
        cycle();
        set_cmd(1, 1'b0, 1'b1, 1'b0, 8'h50, 16'hBEEF);
        cycle();
        set_cmd(1, 1'b0, 1'b0, 1'b0, 8'h50, 16'hCAFE);
        cycle();
        set_idle(1);
        vectors++;
        if (err[1] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL busy_illegal_err got %b want 0", err[1]);
        end
        cycle();
        vectors++;
        if (dv[1] !== 1'b1 || dout1 !== 16'h005A) begin
            miscompares++;
            $display("[TB] FAIL busy_inflight_read got dv=%b data=%h want 1/005a", dv[1], dout1);
        end
        read_op(1, 8'h50, got, lat, bc, d, bdv);
        vectors++;
        if (!got || d !== 16'h0011) begin
            miscompares++;
            $display("[TB] FAIL busy_write_ignored got valid=%0d data=%h want 1/0011", got, d);
        end
    endtask

    task automatic test_illegal();
        bit got; int lat, bc; logic [15:0] d; logic bdv;
        set_cmd(0, 1'b0, 1'b0, 1'b0, 8'h10, 16'h0055);
        cycle();
        set_idle(0);
        vectors++;
        if (err[0] !== 1'b1 || busy[0] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL illegal_pulse got err=%b busy=%b want 1/0", err[0], busy[0]);
        end
        cycle();
        vectors++;
        if (err[0] !== 1'b0 || dv[0] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL illegal_one_cycle got err=%b dv=%b want 0/0", err[0], dv[0]);
        end
        read_op(0, 8'h10, got, lat, bc, d, bdv);
        vectors++;
        if (!got || d !== ref_mem[0][8'h10]) begin
            miscompares++;
            $display("[TB] FAIL illegal_no_write got valid=%0d data=%h want 1/%h", got, d, ref_mem[0][8'h10]);
        end
    endtask

    task automatic test_reset_mid_read();
        bit got; int lat, bc, pulses; logic [15:0] d; logic bdv;
        set_cmd(1, 1'b0, 1'b0, 1'b1, 8'hFF, 16'h0000);
        cycle();
        set_idle(1);
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        vectors++;
        if (dv[1] !== 1'b0 || dout1 !== 16'h0000 || busy[1] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_read got dv=%b data=%h busy=%b want 0/0000/0", dv[1], dout1, busy[1]);
        end
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (dv[1]) pulses++;
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("[TB] FAIL reset_aborts_read got pulses=%0d want 0", pulses);
        end
        read_op(1, 8'hFF, got, lat, bc, d, bdv);
        vectors++;
        if (!got || lat != 3 || d !== 16'h005A) begin
            miscompares++;
            $display("[TB] FAIL reset_keeps_mem got valid=%0d lat=%0d data=%h want 1/3/005a", got, lat, d);
        end
    endtask

    task automatic test_back_to_back();
        bit got; int lat, bc; logic [15:0] d; logic bdv;
        for (int i = 0; i < 4; i++) begin
            set_cmd(0, 1'b0, 1'b1, 1'b0, 8'(8'h30 + i), 16'(8'hC0 + i));
            ref_mem[0][8'h30 + i]   = 16'(8'hC0 + i);
            ref_valid[0][8'h30 + i] = 1'b1;
            cycle();
            vectors++;
            if (busy[0] !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL b2b_write_busy step %0d got %b want 0", i, busy[0]);
            end
        end
        set_idle(0);
        for (int i = 0; i < 4; i++) begin
            read_op(0, 8'(8'h30 + i), got, lat, bc, d, bdv);
            vectors++;
            if (!got || lat != 1 || d !== ref_mem[0][8'h30 + i]) begin
                miscompares++;
                $display("[TB] FAIL b2b_read step %0d got valid=%0d lat=%0d data=%h want 1/1/%h",
                         i, got, lat, d, ref_mem[0][8'h30 + i]);
            end
        end
        cycle();
    endtask

    task automatic test_parity();
`ifdef PARAM_MEM_PARITY_EN
        bit got; int lat, bc; logic [15:0] d; logic bdv;
        write_op(1, 8'h03, 16'h1234);
        set_cmd(1, 1'b0, 1'b0, 1'b1, 8'h03, 16'h0000);
        cycle();
        set_idle(1);
        for (int k = 0; k < 3; k++) cycle();
        vectors++;
        if (dv[1] !== 1'b1 || dout1 !== 16'h1234 || perr[1] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL parity_read got dv=%b data=%h par_err=%b want 1/1234/0", dv[1], dout1, perr[1]);
        end
        read_op(0, 8'h10, got, lat, bc, d, bdv);
        vectors++;
        if (!got || perr[0] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL parity_inst0 got valid=%0d par_err=%b want 1/0", got, perr[0]);
        end
`endif
        cycle();
    endtask

    task automatic test_random();
        bit got; int lat, bc, idx, op; logic [15:0] d, wd; logic bdv; logic [7:0] a;
        for (int n = 0; n < 60; n++) begin
            idx = int'($urandom_range(0, 1));
            op  = int'($urandom_range(0, 4));
            a   = 8'h40 + 8'($urandom_range(0, 15));
            wd  = 16'($urandom) & mask_of(idx);
            if (op <= 1) begin
                write_op(idx, a, wd);
            end else if (op == 2) begin
                read_op(idx, a, got, lat, bc, d, bdv);
                vectors++;
                if (!got || lat != lat_of(idx) || bc != lat_of(idx) ||
                    (ref_valid[idx][a] && d !== ref_mem[idx][a])) begin
                    miscompares++;
                    $display("[TB] FAIL rand_read inst%0d addr %h got valid=%0d lat=%0d busy_cyc=%0d data=%h want lat=%0d data=%h",
                             idx, a, got, lat, bc, d, lat_of(idx), ref_mem[idx][a]);
                end
            end else if (op == 3) begin
                set_cmd(idx, 1'b0, 1'b0, 1'b0, a, wd);
                cycle();
                set_idle(idx);
                vectors++;
                if (err[idx] !== 1'b1 || busy[idx] !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL rand_illegal inst%0d got err=%b busy=%b want 1/0", idx, err[idx], busy[idx]);
                end
            end else begin
                set_cmd(idx, 1'b1, 1'b0, 1'b0, a, wd);
                cycle();
                set_idle(idx);
                vectors++;
                if (err[idx] !== 1'b0 || busy[idx] !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL rand_deselect inst%0d got err=%b busy=%b want 0/0", idx, err[idx], busy[idx]);
                end
            end
        end
        cycle();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_rdlat3();
        test_busy_ignore();
        test_illegal();
        test_reset_mid_read();
        test_back_to_back();
        test_parity();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
